fu_rs: RTL and testbench

- Reservation station feeding one functional unit (e.g. the RAM FU); it drives the FU's dispatch-side interface.
- Buffers up to DEPTH dispatched micro-ops and snoops the CDB for pending operand tags.
- Issues the oldest ready entry to the FU when the FU is not busy, as a single-cycle transmit pulse.

---
 rtl/fu_rs.sv | 169 ++++++++++++++++
 tb/tb_fu_rs.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fu_rs.sv
// fu_rs -- reservation station in front of a single functional unit.
//
// Holds up to DEPTH dispatched micro-ops in a collapsing queue (entry 0 is
// the oldest), snoops the CDB for operands still waiting on a producer, and
// hands the selected ready entry to the FU as a one-cycle issue pulse.
//
// Ports:
//   clk, rst (sync, active-low), flush (sync clear of all entries)
//   disp_*        : dispatch side (valid strobe, operand, per-operand
//                   ready/tag/value, writeback select, flags, ROB id)
//   rs_full       : no free entry (from registered count)
//   rs_count      : number of occupied entries
//   cdb_*         : common data bus broadcast (valid, ROB id, value)
//   fu_busy       : FU cannot accept an op this cycle
//   issue_*       : registered issue pulse plus the issued op's fields
module fu_rs #(
  parameter int DEPTH    = 4,
  parameter bit IN_ORDER = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            disp_valid,
  input  logic [7:0]      disp_operand,
  input  logic [1:0]      disp_dep_ready,
  input  logic [1:0][3:0] disp_dep_tag,
  input  logic [1:0][7:0] disp_dep_val,
  input  logic [7:0]      disp_wbs,
  input  logic [7:0]      disp_flags,
  input  logic [3:0]      disp_robid,
  output logic            rs_full,
  output logic [3:0]      rs_count,
  input  logic            cdb_transmit,
  input  logic [3:0]      cdb_id,
  input  logic [7:0]      cdb_val,
  input  logic            fu_busy,
  output logic            issue_transmit,
  output logic [7:0]      issue_operand,
  output logic [1:0][7:0] issue_depvals,
  output logic [7:0]      issue_wbs,
  output logic [7:0]      issue_flags,
  output logic [3:0]      issue_robid
);

  localparam int         IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  typedef struct packed {
    logic [7:0]      operand;
    logic [1:0]      rdy;
    logic [1:0][3:0] tag;
    logic [1:0][7:0] val;
    logic [7:0]      wbs;
    logic [7:0]      flags;
    logic [3:0]      robid;
  } entry_t;

  // Capture a live CDB broadcast into any operand still waiting on that tag.
  function automatic entry_t cdb_capture(input entry_t e, input logic tx,
                                         input logic [3:0] id, input logic [7:0] v);
    entry_t r;
    r = e;
    for (int k = 0; k < 2; k++) begin
      if (tx && !e.rdy[k] && (e.tag[k] == id)) begin
        r.rdy[k] = 1'b1;
        r.val[k] = v;
      end else begin
        r.rdy[k] = e.rdy[k];
      end
    end
    return r;
  endfunction

  entry_t          ent_r     [DEPTH];
  entry_t          snp_s     [DEPTH];
  entry_t          ent_n_s   [DEPTH];
  entry_t          disp_raw_s;
  entry_t          disp_ent_s;
  logic [3:0]      count_r;
  logic [3:0]      count_n_s;
  logic [IW-1:0]   sel_s;
  logic            found_s;
  logic            do_issue_s;
  logic            do_disp_s;
  int              base_s;

  assign rs_count   = count_r;
  assign rs_full    = (count_r == DEPTH_C);
  // Full blocks dispatch even when an issue frees a slot the same cycle.
  assign do_disp_s  = disp_valid & ~rs_full & ~flush;
  // The issue_transmit term forbids back-to-back issue so the FU can raise busy.
  assign do_issue_s = found_s & ~fu_busy & ~flush & ~issue_transmit;

  // Candidate selection on ready bits as registered at the start of the cycle.
  always_comb begin
    found_s = 1'b0;
    sel_s   = '0;
    if (IN_ORDER) begin
      found_s = (count_r != 4'd0) && (ent_r[0].rdy == 2'b11);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        sel_s   = (!found_s && (i < int'(count_r)) && (ent_r[i].rdy == 2'b11)) ? IW'(i) : sel_s;
        found_s = found_s | ((i < int'(count_r)) && (ent_r[i].rdy == 2'b11));
      end
    end
  end

  // Incoming op, with same-cycle CDB bypass on its waiting operands.
  always_comb begin
    disp_raw_s.operand = disp_operand;
    disp_raw_s.rdy     = disp_dep_ready;
    disp_raw_s.tag     = disp_dep_tag;
    disp_raw_s.val     = disp_dep_val;
    disp_raw_s.wbs     = disp_wbs;
    disp_raw_s.flags   = disp_flags;
    disp_raw_s.robid   = disp_robid;
    disp_ent_s         = cdb_capture(disp_raw_s, cdb_transmit, cdb_id, cdb_val);
  end

  // Next queue image: snoop every slot, collapse above the issued slot,
  // then append the dispatched op at the post-collapse tail.
  always_comb begin
    logic [IW-1:0] src;
    src    = '0;
    base_s = int'(count_r) - (do_issue_s ? 1 : 0);
    for (int i = 0; i < DEPTH; i++) begin
      snp_s[i] = cdb_capture(ent_r[i], cdb_transmit, cdb_id, cdb_val);
    end
    for (int i = 0; i < DEPTH; i++) begin
      src        = (do_issue_s && (i >= int'(sel_s)) && (i < DEPTH - 1)) ? IW'(i + 1) : IW'(i);
      ent_n_s[i] = (do_disp_s && (i == base_s)) ? disp_ent_s : snp_s[src];
    end
    count_n_s = 4'(base_s) + {3'd0, do_disp_s};
  end

  // Entry payload storage; slots at or above the count are don't-care.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_r[i] <= ent_n_s[i];
    end
  end

  // Occupancy and registered issue interface.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_r        <= 4'd0;
      issue_transmit <= 1'b0;
      issue_operand  <= 8'd0;
      issue_depvals  <= 16'd0;
      issue_wbs      <= 8'd0;
      issue_flags    <= 8'd0;
      issue_robid    <= 4'd0;
    end else if (flush) begin
      count_r        <= 4'd0;
      issue_transmit <= 1'b0;
    end else begin
      count_r        <= count_n_s;
      issue_transmit <= do_issue_s;
      if (do_issue_s) begin
        issue_operand <= ent_r[sel_s].operand;
        issue_depvals <= ent_r[sel_s].val;
        issue_wbs     <= ent_r[sel_s].wbs;
        issue_flags   <= ent_r[sel_s].flags;
        issue_robid   <= ent_r[sel_s].robid;
      end
    end
  end

endmodule

// File: tb/tb_fu_rs.sv
// Bench for fu_rs: an in-order and an out-of-order instance share stimulus.
// A queue-based model of each station is stepped every clock and compared
// against the DUT outputs; directed sequences pin the model with literals,
// then a randomized phase exercises the station broadly.
module tb_fu_rs;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [7:0]      operand;
    logic [1:0]      rdy;
    logic [1:0][3:0] tag;
    logic [1:0][7:0] val;
    logic [7:0]      wbs;
    logic [7:0]      flags;
    logic [3:0]      robid;
  } ent_t;

  logic            clk = 1'b0;
  logic            rst, flush, disp_valid, cdb_transmit, fu_busy;
  logic [7:0]      disp_operand, disp_wbs, disp_flags, cdb_val;
  logic [1:0]      disp_dep_ready;
  logic [1:0][3:0] disp_dep_tag;
  logic [1:0][7:0] disp_dep_val;
  logic [3:0]      disp_robid, cdb_id;

  logic            full0, full1, tx0, tx1;
  logic [3:0]      cnt0, cnt1, rob0, rob1;
  logic [7:0]      op0, op1, wbs0, wbs1, fl0, fl1;
  logic [1:0][7:0] dv0, dv1;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fu_rs #(.DEPTH(DEPTH), .IN_ORDER(1'b1)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .disp_valid(disp_valid),
    .disp_operand(disp_operand), .disp_dep_ready(disp_dep_ready),
    .disp_dep_tag(disp_dep_tag), .disp_dep_val(disp_dep_val),
    .disp_wbs(disp_wbs), .disp_flags(disp_flags), .disp_robid(disp_robid),
    .rs_full(full0), .rs_count(cnt0), .cdb_transmit(cdb_transmit),
    .cdb_id(cdb_id), .cdb_val(cdb_val), .fu_busy(fu_busy),
    .issue_transmit(tx0), .issue_operand(op0), .issue_depvals(dv0),
    .issue_wbs(wbs0), .issue_flags(fl0), .issue_robid(rob0));

  fu_rs #(.DEPTH(DEPTH), .IN_ORDER(1'b0)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .disp_valid(disp_valid),
    .disp_operand(disp_operand), .disp_dep_ready(disp_dep_ready),
    .disp_dep_tag(disp_dep_tag), .disp_dep_val(disp_dep_val),
    .disp_wbs(disp_wbs), .disp_flags(disp_flags), .disp_robid(disp_robid),
    .rs_full(full1), .rs_count(cnt1), .cdb_transmit(cdb_transmit),
    .cdb_id(cdb_id), .cdb_val(cdb_val), .fu_busy(fu_busy),
    .issue_transmit(tx1), .issue_operand(op1), .issue_depvals(dv1),
    .issue_wbs(wbs1), .issue_flags(fl1), .issue_robid(rob1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  ent_t q0[$];
  ent_t q1[$];
  ent_t wq[$];
  logic            e_tx   [2];
  logic [7:0]      e_op   [2];
  logic [1:0][7:0] e_dv   [2];
  logic [7:0]      e_wbs  [2];
  logic [7:0]      e_fl   [2];
  logic [3:0]      e_rob  [2];

  function automatic ent_t snoop(input ent_t e);
    ent_t r = e;
    for (int k = 0; k < 2; k++)
      if (cdb_transmit && !e.rdy[k] && e.tag[k] == cdb_id) begin
        r.rdy[k] = 1'b1;
        r.val[k] = cdb_val;
      end
    return r;
  endfunction

  // One clock of the station's rules applied to the working queue wq.
  task automatic step(input bit m, input bit in_order);
    int   c;
    bit   iss, dsp;
    ent_t e;
    if (!rst) begin
      wq.delete();
      e_tx[m] = 1'b0; e_op[m] = 8'd0; e_dv[m] = 16'd0;
      e_wbs[m] = 8'd0; e_fl[m] = 8'd0; e_rob[m] = 4'd0;
    end else if (flush) begin
      wq.delete();
      e_tx[m] = 1'b0;
    end else begin
      c = -1;
      for (int k = 0; k < wq.size(); k++)
        if (c < 0 && wq[k].rdy == 2'b11 && (!in_order || k == 0)) c = k;
      iss = (c >= 0) && !fu_busy && !e_tx[m];
      dsp = disp_valid && (wq.size() < DEPTH);
      if (iss) begin
        e_op[m] = wq[c].operand; e_dv[m] = wq[c].val; e_wbs[m] = wq[c].wbs;
        e_fl[m] = wq[c].flags;   e_rob[m] = wq[c].robid;
        wq.delete(c);
      end
      e_tx[m] = iss;
      foreach (wq[k]) wq[k] = snoop(wq[k]);
      if (dsp) begin
        e.operand = disp_operand; e.rdy = disp_dep_ready; e.tag = disp_dep_tag;
        e.val = disp_dep_val; e.wbs = disp_wbs; e.flags = disp_flags; e.robid = disp_robid;
        wq.push_back(snoop(e));
      end
    end
  endtask

  task automatic compare(input bit m);
    string p = m ? "d1" : "d0";
    int    sz = m ? q1.size() : q0.size();
    check({p, "_count"}, 32'(m ? cnt1 : cnt0), 32'(sz));
    check({p, "_full"},  32'(m ? full1 : full0), 32'(sz == DEPTH));
    check({p, "_tx"},    32'(m ? tx1 : tx0), 32'(e_tx[m]));
    check({p, "_robid"}, 32'(m ? rob1 : rob0), 32'(e_rob[m]));
    check({p, "_oper"},  32'(m ? op1 : op0), 32'(e_op[m]));
    check({p, "_depv"},  32'(m ? dv1 : dv0), 32'(e_dv[m]));
    check({p, "_wbs"},   32'(m ? wbs1 : wbs0), 32'(e_wbs[m]));
    check({p, "_flags"}, 32'(m ? fl1 : fl0), 32'(e_fl[m]));
  endtask

  // Compare process: advance both models on each edge, check just after it.
  always @(posedge clk) begin
    wq = q0; step(1'b0, 1'b1); q0 = wq;
    wq = q1; step(1'b1, 1'b0); q1 = wq;
    #1;
    compare(1'b0);
    compare(1'b1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic idle();
    disp_valid = 1'b0; cdb_transmit = 1'b0; flush = 1'b0;
  endtask

  task automatic disp(input logic [3:0] rob, input logic [1:0] rdy,
                      input logic [3:0] t0, input logic [3:0] t1,
                      input logic [7:0] v0, input logic [7:0] v1, input logic [7:0] fl);
    disp_valid = 1'b1; disp_robid = rob; disp_dep_ready = rdy;
    disp_dep_tag[0] = t0; disp_dep_tag[1] = t1;
    disp_dep_val[0] = v0; disp_dep_val[1] = v1;
    disp_flags = fl; disp_operand = {rob, 4'h9}; disp_wbs = {4'h0, rob};
  endtask

  task automatic cdb(input logic [3:0] id, input logic [7:0] v);
    cdb_transmit = 1'b1; cdb_id = id; cdb_val = v;
  endtask

  int pulses, b2b;
  logic prev;

  initial begin
    rst = 1'b0; fu_busy = 1'b0; idle();
    disp_operand = 8'd0; disp_dep_ready = 2'b00; disp_dep_tag = 8'd0;
    disp_dep_val = 16'd0; disp_wbs = 8'd0; disp_flags = 8'd0; disp_robid = 4'd0;
    cdb_id = 4'd0; cdb_val = 8'd0;
    nxt(); nxt();
    check("reset_count", 32'(cnt0), 32'd0);
    check("reset_tx", 32'(tx0), 32'd0);
    check("reset_robid", 32'(rob0), 32'd0);

    // Fully ready op into an empty station.
    rst = 1'b1;
    disp(4'd3, 2'b11, 4'd0, 4'd0, 8'h10, 8'h20, 8'h02);
    nxt(); idle();
    check("t1_count1", 32'(cnt0), 32'd1);
    check("t1_no_tx_yet", 32'(tx0), 32'd0);
    nxt();
    check("t1_tx", 32'(tx0), 32'd1);
    check("t1_robid", 32'(rob0), 32'd3);
    check("t1_dv0", 32'(dv0[0]), 32'h10);
    check("t1_dv1", 32'(dv0[1]), 32'h20);
    check("t1_flags", 32'(fl0), 32'h02);
    check("t1_count0", 32'(cnt0), 32'd0);
    nxt();
    check("t1_single_pulse", 32'(tx0), 32'd0);

    // Operand 1 waits on tag 5; a non-matching broadcast first.
    disp(4'd1, 2'b01, 4'd0, 4'd5, 8'h11, 8'h00, 8'h00);
    nxt(); idle(); cdb(4'd6, 8'h99);
    nxt(); idle();
    check("t2_wrong_tag_no_tx", 32'(tx0), 32'd0);
    check("t2_still_queued", 32'(cnt0), 32'd1);
    cdb(4'd5, 8'hAB);
    nxt(); idle();
    check("t2_not_same_cycle", 32'(tx0), 32'd0);
    nxt();
    check("t2_tx", 32'(tx0), 32'd1);
    check("t2_dv1", 32'(dv0[1]), 32'hAB);
    check("t2_robid", 32'(rob0), 32'd1);

    // Entry 0 waits, entry 1 ready: in-order holds, out-of-order takes entry 1.
    nxt();
    disp(4'd2, 2'b10, 4'd4, 4'd0, 8'h00, 8'h22, 8'h00);
    nxt();
    disp(4'd3, 2'b11, 4'd0, 4'd0, 8'h33, 8'h34, 8'h00);
    nxt(); idle();
    nxt();
    check("t3_ooo_tx", 32'(tx1), 32'd1);
    check("t3_ooo_robid", 32'(rob1), 32'd3);
    check("t3_ino_hold", 32'(tx0), 32'd0);
    check("t3_ino_count", 32'(cnt0), 32'd2);
    cdb(4'd4, 8'h44);
    nxt(); idle();
    check("t3_ino_wait", 32'(tx0), 32'd0);
    nxt();
    check("t3_ino_tx_a", 32'(tx0), 32'd1);
    check("t3_ino_rob_a", 32'(rob0), 32'd2);
    check("t3_ino_dv_a", 32'(dv0[0]), 32'h44);
    check("t3_ooo_rob_a", 32'(rob1), 32'd2);
    nxt();
    check("t3_no_b2b", 32'(tx0), 32'd0);
    check("t3_count1", 32'(cnt0), 32'd1);
    nxt();
    check("t3_ino_tx_b", 32'(tx0), 32'd1);
    check("t3_ino_rob_b", 32'(rob0), 32'd3);

    // Fill while the FU is busy; the fifth dispatch is dropped.
    fu_busy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      disp(4'(8 + k), 2'b11, 4'd0, 4'd0, 8'(k), 8'(k + 1), 8'h00);
      nxt();
    end
    idle();
    check("t4_count4", 32'(cnt0), 32'd4);
    check("t4_full", 32'(full0), 32'd1);
    fu_busy = 1'b0;
    nxt();
    check("t4_first_tx", 32'(tx0), 32'd1);
    check("t4_first_rob", 32'(rob0), 32'd8);
    check("t4_not_full", 32'(full0), 32'd0);
    pulses = 1; b2b = 0; prev = 1'b1;
    for (int k = 0; k < 7; k++) begin
      nxt();
      if (tx0) pulses++;
      if (tx0 && prev) b2b++;
      prev = tx0;
    end
    check("t4_pulses", 32'(pulses), 32'd4);
    check("t4_back_to_back", 32'(b2b), 32'd0);

    // Dispatch bypass: tag 7 resolved by the broadcast in the dispatch cycle.
    disp(4'd5, 2'b10, 4'd7, 4'd0, 8'h00, 8'h66, 8'h00);
    cdb(4'd7, 8'h55);
    nxt(); idle();
    nxt();
    check("t5_tx", 32'(tx0), 32'd1);
    check("t5_dv0", 32'(dv0[0]), 32'h55);
    check("t5_robid", 32'(rob0), 32'd5);

    // Flush mid-stream, with a dispatch in the flush cycle.
    nxt();
    fu_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      disp(4'(9 + k), 2'b11, 4'd0, 4'd0, 8'h01, 8'h02, 8'h00);
      nxt();
    end
    check("t6_count3", 32'(cnt0), 32'd3);
    flush = 1'b1;
    disp(4'd12, 2'b11, 4'd0, 4'd0, 8'h01, 8'h02, 8'h00);
    nxt(); idle();
    check("t6_flush_count", 32'(cnt0), 32'd0);
    check("t6_flush_tx", 32'(tx0), 32'd0);
    check("t6_data_held", 32'(rob0), 32'd5);
    nxt();
    check("t6_disp_dropped", 32'(cnt0), 32'd0);

    // Reset mid-stream clears data outputs too.
    for (int k = 0; k < 3; k++) begin
      disp(4'(9 + k), 2'b11, 4'd0, 4'd0, 8'h01, 8'h02, 8'h00);
      nxt();
    end
    check("t7_count3", 32'(cnt0), 32'd3);
    rst = 1'b0;
    nxt(); rst = 1'b1; idle();
    check("t7_rst_count", 32'(cnt0), 32'd0);
    check("t7_rst_tx", 32'(tx0), 32'd0);
    check("t7_rst_robid", 32'(rob0), 32'd0);
    nxt();
    check("t7_disp_dropped", 32'(cnt0), 32'd0);
    fu_busy = 1'b0;

    // Randomized phase.
    for (int n = 0; n < 3000; n++) begin
      nxt();
      rst            = ($urandom_range(0, 199) != 0);
      flush          = ($urandom_range(0, 59) == 0);
      fu_busy        = ($urandom_range(0, 3) == 0);
      disp_valid     = ($urandom_range(0, 1) == 1);
      disp_operand   = 8'($urandom);
      disp_dep_ready = {($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6)};
      disp_dep_tag[0] = 4'($urandom_range(0, 7));
      disp_dep_tag[1] = 4'($urandom_range(0, 7));
      disp_dep_val   = 16'($urandom);
      disp_wbs       = 8'($urandom);
      disp_flags     = 8'($urandom);
      disp_robid     = 4'($urandom);
      cdb_transmit   = ($urandom_range(0, 1) == 1);
      cdb_id         = 4'($urandom_range(0, 7));
      cdb_val        = 8'($urandom);
    end
    nxt(); idle();
    nxt(); nxt();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
